// File: rtl/instruction_sequencer.sv
// Buffers host instruction words in a FIFO and issues one registered word per cycle to the cpu,
// streaming burst-write data back-to-back and filling burst-read/operate latency with NOPs.
module instruction_sequencer #(
  parameter int FIFO_DEPTH        = 8,
  parameter int BURST_WRITE_WORDS = 5,
  parameter int BURST_READ_WAIT   = 9,
  parameter int OPERATE_WAIT      = 4
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic [15:0]                 host_instruction_in,
  input  logic                        host_valid_in,
  output logic                        host_ready_out,
  output logic [15:0]                 instruction_out,
  output logic                        issue_valid_out,
  output logic                        busy_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
  output logic [15:0]                 issued_count_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = 8;

  // ISSUE: decode FIFO head | BW_DATA: stream burst data raw | WAIT: NOP fill
  localparam logic [1:0] ST_ISSUE   = 2'd0;
  localparam logic [1:0] ST_BW_DATA = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] remaining;
  logic [15:0]   head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          head_bw;
  logic          head_br;
  logic          head_op;

  assign head           = mem[rd_ptr];
  assign empty          = (count == '0);
  assign host_ready_out = (count < CW'(FIFO_DEPTH));
  assign push           = host_valid_in && host_ready_out;
  assign head_bw        = (head[1:0] == 2'b11) && head[2];
  assign head_br        = (head[1:0] == 2'b11) && !head[2];
  assign head_op        = (head[1:0] == 2'b10);
  assign fifo_count_out = count;
  assign busy_out       = (state != ST_ISSUE) || !empty;

  // A burst-write header is only released once all of its data words are buffered.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_ISSUE:   pop = !empty && !(head_bw && (count < CW'(1 + BURST_WRITE_WORDS)));
      ST_BW_DATA: pop = !empty;
      default:    pop = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (push) mem[wr_ptr] <= host_instruction_in;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      state            <= ST_ISSUE;
      wait_cnt         <= '0;
      remaining        <= '0;
      instruction_out  <= 16'h0000;
      issue_valid_out  <= 1'b0;
      issued_count_out <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count           <= count + CW'(push) - CW'(pop);
      instruction_out <= pop ? head : 16'h0000;
      issue_valid_out <= pop;
      if (pop) issued_count_out <= issued_count_out + 16'd1;

      case (state)
        ST_ISSUE: begin
          if (pop) begin
            if (head_bw) begin
              remaining <= TW'(BURST_WRITE_WORDS);
              state     <= ST_BW_DATA;
            end else if (head_br) begin
              wait_cnt <= TW'(BURST_READ_WAIT);
              state    <= ST_WAIT;
            end else if (head_op) begin
              wait_cnt <= TW'(OPERATE_WAIT);
              state    <= ST_WAIT;
            end
          end
        end
        ST_BW_DATA: begin
          if (remaining <= TW'(1)) begin
            remaining <= '0;
            state     <= ST_ISSUE;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= TW'(1)) begin
            wait_cnt <= '0;
            state    <= ST_ISSUE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: stimulus queues pushed words, a per-cycle monitor
// applies the issue rules to that queue and compares every DUT output.
module tb_instruction_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] host_instr = 16'h0000;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [15:0] instr;
  logic        issue_valid;
  logic        busy;
  logic [3:0]  fcount;
  logic [15:0] issued;

  instruction_sequencer #(
    .FIFO_DEPTH(8), .BURST_WRITE_WORDS(5), .BURST_READ_WAIT(9), .OPERATE_WAIT(4)
  ) dut (
    .clock_in(clk), .reset_in(rst),
    .host_instruction_in(host_instr), .host_valid_in(host_valid), .host_ready_out(host_ready),
    .instruction_out(instr), .issue_valid_out(issue_valid), .busy_out(busy),
    .fifo_count_out(fcount), .issued_count_out(issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    int          edge_n;
  } ent_t;

  ent_t        exp_q[$];
  int          cyc = 0;
  int          stall_left = 0;
  int          bw_left = 0;
  logic [15:0] model_issued = 16'h0000;
  bit          model_on = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    stall_left   = 0;
    bw_left      = 0;
    model_issued = 16'h0000;
  endtask

  // Words pushed at edge N become eligible for issue at edge N+1.
  task automatic model_step();
    int          avail;
    int          now_cnt;
    logic        exp_v;
    logic [15:0] w;
    logic [15:0] exp_w;
    avail = 0;
    foreach (exp_q[i]) if (exp_q[i].edge_n <= cyc - 1) avail++;
    exp_v = 1'b0;
    exp_w = 16'h0000;
    if (stall_left > 0) begin
      stall_left--;
    end else if (bw_left > 0) begin
      exp_v = 1'b1;
      bw_left--;
    end else if (avail > 0) begin
      w = exp_q[0].w;
      if (w[1:0] == 2'b11 && w[2]) begin
        if (avail >= 6) begin
          exp_v   = 1'b1;
          bw_left = 5;
        end
      end else begin
        exp_v = 1'b1;
        if (w[1:0] == 2'b11)      stall_left = 9;
        else if (w[1:0] == 2'b10) stall_left = 4;
      end
    end
    if (exp_v && exp_q.size() > 0) begin
      exp_w = exp_q[0].w;
      void'(exp_q.pop_front());
      model_issued = model_issued + 16'd1;
    end
    now_cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].edge_n <= cyc) now_cnt++;
    check("issue_valid", 32'(issue_valid), 32'(exp_v));
    check("instruction", 32'(instr), 32'(exp_w));
    check("issued_count", 32'(issued), 32'(model_issued));
    check("fifo_count", 32'(fcount), 32'(now_cnt));
    check("busy", 32'(busy), 32'(stall_left > 0 || bw_left > 0 || now_cnt > 0));
    check("host_ready", 32'(host_ready), 32'(now_cnt < 8));
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (model_on && !rst) model_step();
  end

  // Called at a negedge; holds the word until accepted.
  task automatic push_word(input logic [15:0] w);
    int   tries;
    ent_t e;
    tries = 0;
    host_instr = w;
    host_valid = 1'b1;
    while (!host_ready && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    if (!host_ready) begin
      check("push_timeout", 32'(host_ready), 32'd1);
      host_valid = 1'b0;
      return;
    end
    e.w = w;
    e.edge_n = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_valid", 32'(issue_valid), 32'h0);
    check("rst_count", 32'(fcount), 32'h0);
    check("rst_issued", 32'(issued), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    idle(2);
    rst = 1'b0;
    model_reset();
    model_on = 1'b1;
    check("ready_after_reset", 32'(host_ready), 32'd1);

    push_word(16'h0815);
    push_word(16'h1201);
    idle(3);
    check("single_issued", 32'(issued), 32'd2);

    push_word(16'h0007);
    push_word(16'h0003);
    push_word(16'h0002);
    push_word(16'h000B);
    idle(6);
    check("bw_held_count", 32'(fcount), 32'd4);
    check("bw_held_nop", 32'(issue_valid), 32'd0);
    push_word(16'h0013);
    push_word(16'hFFFF);
    idle(10);
    check("bw_done_busy", 32'(busy), 32'd0);

    push_word(16'h0003);
    push_word(16'h0815);
    idle(14);

    push_word(16'h0002);
    push_word(16'h0001);
    idle(8);

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [15:0] w;
          w = {i[13:0], (i % 2 == 0) ? 2'b10 : 2'b01};
          push_word(w);
        end
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          if (fcount == 4'd8) begin
            seen = 1'b1;
            check("ready_when_full", 32'(host_ready), 32'd0);
          end
        end
        check("full_reached", 32'(seen), 32'd1);
      end
    join
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      int unsigned k;
      logic [15:0] w;
      r = $urandom;
      w = r[15:0];
      k = $urandom_range(0, 9);
      if (k == 0) begin
        w[2:0] = 3'b111;
        push_word(w);
        for (int j = 0; j < 5; j++) begin
          r = $urandom;
          w = r[15:0];
          push_word(w);
        end
      end else begin
        if (k == 1)      w[2:0] = 3'b011;
        else if (k == 2) w[1:0] = 2'b10;
        else             w[1] = 1'b0;
        push_word(w);
      end
      idle($urandom_range(0, 2));
    end
    wait_drain();

    push_word(16'h0F0F);
    push_word(16'hA1A0);
    push_word(16'hB2B0);
    push_word(16'hC3C0);
    push_word(16'hD4D0);
    push_word(16'hE5E0);
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
        @(posedge clk);
        #2;
        if (issue_valid && instr == 16'hB2B0) found = 1'b1;
      end
      check("second_data_seen", 32'(found), 32'd1);
    end
    #1;
    rst = 1'b1;
    #1;
    check("midrst_instr", 32'(instr), 32'h0);
    check("midrst_valid", 32'(issue_valid), 32'h0);
    check("midrst_count", 32'(fcount), 32'h0);
    check("midrst_issued", 32'(issued), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    check("no_data_after_reset", 32'(issued), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Upstream feeder for the `cpu` block. It accepts 16-bit instruction words from a host over a valid/ready handshake and buffers them in a FIFO. It drives `cpu.current_instruction` one registered word per `clock_in` cycle. It enforces the cpu's multi-cycle rules:
- burst-write data words go out back-to-back with no gaps;
- NOPs are inserted while a burst read or a tensor-core operation is in flight.

## Interface
Parameters:
- FIFO_DEPTH, 8, instruction FIFO entries; power of two, must be ≥ 8 so that a full burst write (header plus 5 data words) fits.
- BURST_WRITE_WORDS, 5, data words that follow a burst-write header.
- BURST_READ_WAIT, 9, NOP cycles issued after a burst-read header.
- OPERATE_WAIT, 4, NOP cycles issued after a tensor-core operate instruction.

Ports:
- clock_in  input  1  system clock; all state updates on the posedge.
- reset_in  input  1  asynchronous, active-high reset.
- host_instruction_in  input  16  instruction word from the host.
- host_valid_in  input  1  host word is valid.
- host_ready_out  output  1  FIFO can accept a word (`count < FIFO_DEPTH`).
- instruction_out  output  16  registered; connects to `cpu.current_instruction`.
- issue_valid_out  output  1  registered; 1 when instruction_out holds a dequeued word, 0 when it holds an inserted NOP.
- busy_out  output  1  FSM is not in ISSUE, or the FIFO is non-empty.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- issued_count_out  output  16  count of dequeued words issued; wraps modulo 2^16.

## Operation
- **Encodings.** NOP = 16'h0000. Opcode = word[1:0].
  - Burst write: opcode 2'b11 with bit2 = 1. Burst read: opcode 2'b11 with bit2 = 0.
  - Operate: opcode 2'b10.
  - Reset instruction: opcode 2'b00 with word[3:2] = 2'b11.
  - Every other word is single-cycle.
- **FIFO push.** A word is pushed when host_valid_in && host_ready_out. There is no bypass: a push and a pop in the same cycle are both legal, and count is unchanged.
- **ISSUE state**, evaluated each cycle on the FIFO head:
  - FIFO empty: issue NOP, issue_valid_out = 0.
  - Head is a burst-write header and count < 1+BURST_WRITE_WORDS: issue NOP and hold the head.
  - Head is a burst-write header and count ≥ 1+BURST_WRITE_WORDS: pop and issue the header, load remaining = BURST_WRITE_WORDS, go to BW_DATA.
  - Head is a burst-read header: pop and issue, load wait = BURST_READ_WAIT, go to WAIT.
  - Head is an operate: pop and issue, load wait = OPERATE_WAIT, go to WAIT.
  - Any other word: pop and issue, stay in ISSUE.
- **BW_DATA.** Pop and issue one word per cycle, raw and not decoded, and decrement remaining. Return to ISSUE after the cycle that issues the last data word. Data availability is guaranteed by the entry check in ISSUE.
- **WAIT.** Issue NOP and decrement wait. Return to ISSUE after the cycle in which wait reaches 1. A reset instruction arriving at the head during WAIT is not bypassed; it waits its turn.
- **Counters.**
  - issued_count_out increments on every pop, including burst data words.
  - A reset instruction is issued normally and does not clear sequencer state.
- **reset_in asserted (asynchronous):**
  - FIFO emptied; count = 0.
  - State = ISSUE; wait and remaining = 0.
  - instruction_out = 16'h0000; issue_valid_out = 0.
  - issued_count_out = 0; busy_out = 0; host_ready_out = 1 once reset is released.
  - Reset mid-burst or mid-wait aborts the operation; no further data words are issued.

## Timing
- A word pushed at posedge N is issued at the earliest at posedge N+1, when it becomes visible on instruction_out. It stays on instruction_out for exactly one cycle.
- A burst-write header at posedge M is followed by data words at M+1 … M+5 with no bubbles. The next non-burst word is at M+6 at the earliest.
- A burst-read header at M is followed by NOPs at M+1 … M+9. The next word is at M+10 at the earliest.
- An operate at M is followed by NOPs at M+1 … M+4. The next word is at M+5 at the earliest.
- host_ready_out is combinational from count: it is 0 when full. A push attempted while full is ignored and the host must hold the word.
- FIFO read and write pointers wrap modulo FIFO_DEPTH. Full is detected from count, not from pointer equality alone.

## Test plan
- **Single-cycle words.** After reset, push 16'h0815 and 16'h1201 on consecutive cycles. Required:
  - outputs 0815 and then 1201 on consecutive cycles, each with issue_valid_out = 1;
  - issued_count_out = 2;
  - then NOP with issue_valid_out = 0.
- **Burst-write gating.** Push header 16'h0007 and only 3 data words. Required: NOPs are issued and the header is held. Push 2 more data words. Required: header plus 5 data words appear on 6 consecutive cycles, then busy_out = 0.
- **Burst read.** Push 16'h0003 and then 16'h0815. Required: 0003, then 9 NOPs with issue_valid_out = 0, then 0815.
- **Operate.** Push 16'h0002 and then 16'h0001. Required: 0002, then exactly 4 NOPs, then 0001.
- **Full and wrap.** Hold output in WAIT via an operate, then push until full. Required:
  - host_ready_out = 0 at count = 8;
  - a push attempted while full is dropped;
  - after draining, the 20 words pushed in total are issued in order, exercising pointer wrap.
- **Reset mid-burst.** Assert reset_in asynchronously after the second burst-write data word. Required: instruction_out = 0, count = 0, issued_count_out = 0 immediately; after release, the remaining data words are never issued.
